dsp_mult_scheduler: RTL and testbench

- Shares one pipelined 18x18 signed multiplier (DSP48E1 slice, MULTIPLY mode) between NUM_REQ requesters.
- Round-robin arbitration; one operand pair issued per cycle.
- Each issue is tagged with its requester ID; the tag travels with the data through the pipeline.
- Single shared result port with backpressure, implemented as a global clock-enable stall.
- Sits between multiple fabric producers and the DSP column; used as a fuzzer/minitest datapath controller.

---
 rtl/dsp_mult_scheduler_pkg.sv | 22 ++
 rtl/dsp_mult_scheduler_if.sv | 27 ++
 rtl/dsp_mult_pipe.sv | 84 ++++++++
 rtl/dsp_mult_scheduler.sv | 86 ++++++++
 tb/tb_dsp_mult_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_mult_scheduler_pkg.sv
// Shared constants, tag type and helpers for the DSP multiplier scheduler.
package dsp_sched_pkg;

  localparam int P_WIDTH     = 36;
  localparam int MAX_LATENCY = 4;
  localparam int MAX_ID_W    = 3;

  function automatic int f_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Requester tag that travels alongside the operands through the multiplier
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/dsp_mult_scheduler_if.sv
// Request/result bus between fabric producers, the consumer and the scheduler.
interface dsp_mult_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18
);
  localparam int ID_W = dsp_sched_pkg::f_clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*A_WIDTH-1:0]        req_a;
  logic [NUM_REQ*B_WIDTH-1:0]        req_b;
  logic                              res_valid;
  logic                              res_ready;
  logic signed [A_WIDTH+B_WIDTH-1:0] res_p;
  logic [ID_W-1:0]                   res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id
  );
endinterface

// File: rtl/dsp_mult_pipe.sv
// Pipelined signed multiplier with a tag shift register aligned to its stages.
module dsp_mult_pipe import dsp_sched_pkg::*; #(
  parameter int LATENCY = 3,
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_ce,
  input  logic signed [A_WIDTH-1:0]         i_a,
  input  logic signed [B_WIDTH-1:0]         i_b,
  input  tag_t                              i_tag,
  output logic signed [A_WIDTH+B_WIDTH-1:0] o_p,
  output tag_t                              o_tag,
  output logic                              o_busy
);
  localparam int PW = A_WIDTH + B_WIDTH;

  tag_t r_tag [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else if (i_ce) begin
      r_tag[0] <= i_tag;
      for (int unsigned i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) o_busy = o_busy | r_tag[i].valid;
  end

  assign o_tag = r_tag[LATENCY-1];

`ifdef DSP_SCHED_USE_DSP48E1
  // Register split: 1 -> P; 2 -> M,P; 3 -> A/B,M,P; 4 -> A/B x2,M,P
  localparam int ABREG = (LATENCY >= 4) ? 2 : ((LATENCY == 3) ? 1 : 0);
  localparam int MREG  = (LATENCY >= 2) ? 1 : 0;

  logic [29:0] w_a30;
  logic [47:0] w_p48;
  assign w_a30 = {{(30-A_WIDTH){i_a[A_WIDTH-1]}}, i_a};

  DSP48E1 #(
    .A_INPUT("DIRECT"), .B_INPUT("DIRECT"), .USE_DPORT("FALSE"),
    .USE_MULT("MULTIPLY"), .USE_SIMD("ONE48"),
    .AREG(ABREG), .BREG(ABREG), .ACASCREG(ABREG), .BCASCREG(ABREG),
    .MREG(MREG), .PREG(1), .ADREG(0), .DREG(0), .CREG(0),
    .OPMODEREG(0), .ALUMODEREG(0), .INMODEREG(0),
    .CARRYINREG(0), .CARRYINSELREG(0)
  ) u_dsp (
    .CLK(clk), .A(w_a30), .B(i_b), .C(48'd0), .D(25'd0),
    .ACIN(30'd0), .BCIN(18'd0), .PCIN(48'd0),
    .CARRYIN(1'b0), .CARRYCASCIN(1'b0), .MULTSIGNIN(1'b0),
    .OPMODE(7'b0000101), .ALUMODE(4'b0000), .INMODE(5'b00000), .CARRYINSEL(3'b000),
    .CEA1(i_ce), .CEA2(i_ce), .CEB1(i_ce), .CEB2(i_ce), .CEM(i_ce), .CEP(i_ce),
    .CEAD(1'b0), .CED(1'b0), .CEC(1'b0), .CECTRL(1'b0), .CEALUMODE(1'b0),
    .CEINMODE(1'b0), .CECARRYIN(1'b0),
    .RSTA(rst), .RSTB(rst), .RSTM(rst), .RSTP(rst), .RSTC(1'b0), .RSTD(1'b0),
    .RSTCTRL(1'b0), .RSTALLCARRYIN(1'b0), .RSTALUMODE(1'b0), .RSTINMODE(1'b0),
    .P(w_p48), .ACOUT(), .BCOUT(), .PCOUT(), .CARRYOUT(), .CARRYCASCOUT(),
    .MULTSIGNOUT(), .OVERFLOW(), .UNDERFLOW(), .PATTERNDETECT(), .PATTERNBDETECT()
  );

  // DSP reset is synchronous, so the tag masks stale P until it clears
  assign o_p = o_tag.valid ? signed'(w_p48[P_WIDTH-1:0]) : '0;
`else
  logic signed [PW-1:0] r_p [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) r_p[i] <= '0;
    end else if (i_ce) begin
      r_p[0] <= i_a * i_b;
      for (int unsigned i = 1; i < LATENCY; i++) r_p[i] <= r_p[i-1];
    end
  end

  assign o_p = r_p[LATENCY-1];
`endif

endmodule

// File: rtl/dsp_mult_scheduler.sv
// Round-robin scheduler sharing one pipelined signed multiplier among requesters.
module dsp_mult_scheduler import dsp_sched_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3,
  parameter int A_WIDTH      = 18,
  parameter int B_WIDTH      = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 idle,
  dsp_mult_scheduler_if.slave  bus
);
  localparam int ID_W = f_clog2(NUM_REQ);

  logic [ID_W-1:0]                   r_ptr;
  logic [ID_W-1:0]                   w_idx;
  logic [ID_W-1:0]                   w_grant;
  logic                              w_found;
  logic                              w_stall;
  logic                              w_fire;
  logic                              w_busy;
  logic signed [A_WIDTH-1:0]         w_a;
  logic signed [B_WIDTH-1:0]         w_b;
  logic signed [A_WIDTH+B_WIDTH-1:0] w_p;
  tag_t                              w_tag_in;
  tag_t                              w_tag_out;
  logic                              w_unused_id;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_stall = bus.res_valid & ~bus.res_ready;
  assign w_fire  = w_found & en & ~w_stall & ~rst;

  always_comb begin
    bus.req_ready = '0;
    if (w_fire) bus.req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (w_fire)
      r_ptr <= (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + 1'b1;
  end

  assign w_a            = bus.req_a[w_grant*A_WIDTH +: A_WIDTH];
  assign w_b            = bus.req_b[w_grant*B_WIDTH +: B_WIDTH];
  assign w_tag_in.valid = w_fire;
  assign w_tag_in.id    = MAX_ID_W'(w_grant);

  dsp_mult_pipe #(
    .LATENCY (MULT_LATENCY),
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (~w_stall),
    .i_a    (w_a),
    .i_b    (w_b),
    .i_tag  (w_tag_in),
    .o_p    (w_p),
    .o_tag  (w_tag_out),
    .o_busy (w_busy)
  );

  assign bus.res_valid = w_tag_out.valid;
  assign bus.res_p     = w_p;
  assign bus.res_id    = w_tag_out.id[ID_W-1:0];
  assign w_unused_id   = ^w_tag_out.id;
  assign idle          = ~w_busy & ~w_fire;

endmodule

// File: tb/tb_dsp_mult_scheduler.sv
// Directed and randomized bench with a queue-based reference model.
module tb_dsp_mult_scheduler;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int AW  = 18;
  localparam int BW  = 18;

  logic clk, rst, en, idle;
  int n_tests = 0;
  int n_fail  = 0;

  dsp_mult_scheduler_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW)) bus();

  dsp_mult_scheduler #(
    .NUM_REQ(NR), .MULT_LATENCY(LAT), .A_WIDTH(AW), .B_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .idle(idle), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-flight entry: product, requester, cycles advanced since issue
  typedef struct { longint p; int id; int age; } ent_t;
  typedef struct { longint p; int id; } res_t;

  ent_t q[$];
  res_t got[$];
  bit                   rv [NR];
  logic signed [AW-1:0] ra [NR];
  logic signed [BW-1:0] rb [NR];
  bit                   rr, t_en;
  int                   m_ptr;
  bit                   last_fire, obs_valid, obs_idle;
  int                   last_g;
  logic [NR-1:0]        obs_ready;
  logic signed [63:0]   obs_p;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    rv[i] = 1'b1;
    ra[i] = AW'($urandom);
    rb[i] = BW'($urandom);
  endtask

  task automatic set_req(input int i, input longint a, input longint b);
    rv[i] = 1'b1;
    ra[i] = AW'(a);
    rb[i] = BW'(b);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_p", bus.res_p, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_idle", idle, 1);
    q.delete();
    got.delete();
    m_ptr = 0;
    for (int i = 0; i < NR; i++) rv[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_reset();
  endtask

  // One clock: drive at negedge, compare against the model, advance the model at posedge
  task automatic step();
    bit found, fire, exp_valid, stall;
    int g, idx;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]          = rv[i];
      bus.req_a[i*AW +: AW]     = ra[i];
      bus.req_b[i*BW +: BW]     = rb[i];
    end
    bus.res_ready = rr;
    en            = t_en;
    #1;
    exp_valid = (q.size() > 0) && (q[0].age == LAT);
    stall     = exp_valid && !rr;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (!found && rv[idx]) begin found = 1'b1; g = idx; end
    end
    fire      = found && t_en && !stall;
    exp_ready = fire ? (NR'(1) << g) : '0;
    obs_valid = bus.res_valid;
    obs_idle  = idle;
    obs_ready = bus.req_ready;
    obs_p     = bus.res_p;
    chk("res_valid", bus.res_valid, exp_valid);
    if (exp_valid) begin
      chk("res_p", bus.res_p, q[0].p);
      chk("res_id", bus.res_id, q[0].id);
    end
    chk("req_ready", bus.req_ready, exp_ready);
    chk("idle", idle, (q.size() == 0) && !fire);
    if (bus.res_valid && rr) got.push_back('{p: longint'(bus.res_p), id: int'(bus.res_id)});
    @(posedge clk);
    if (!stall) begin
      if (exp_valid) void'(q.pop_front());
      if (fire) begin
        q.push_back('{p: longint'(ra[g]) * longint'(rb[g]), id: g, age: 0});
        m_ptr = (g + 1) % NR;
        rv[g] = 1'b0;
      end
      foreach (q[j]) q[j].age++;
    end
    last_fire = fire;
    last_g    = g;
  endtask

  task automatic drain();
    bit pending;
    for (int c = 0; c < 80; c++) begin
      pending = (q.size() > 0);
      for (int i = 0; i < NR; i++) pending = pending | rv[i];
      if (!pending) break;
      step();
    end
    step();
    chk("drain_idle", obs_idle, 1);
  endtask

  initial begin
    int lat, reqs, seen;
    logic signed [63:0] held_p;
    rst = 1'b1; en = 1'b0; rr = 1'b1; t_en = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < NR; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; end
    apply_reset();

    // Single request from requester 2
    set_req(2, 3, -5);
    step();
    chk("t1_grant", last_g, 2);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (obs_valid && lat == 0) lat = k;
    end
    chk("t1_latency", lat, 3);
    chk("t1_count", got.size(), 1);
    if (got.size() > 0) begin
      chk("t1_p", got[0].p, -15);
      chk("t1_id", got[0].id, 2);
    end

    // All requesters continuously valid
    do_reset();
    for (int i = 0; i < NR; i++) new_req(i);
    for (int c = 0; c < 12; c++) begin
      step();
      chk("t2_fire", last_fire, 1);
      chk("t2_order", last_g, c % NR);
      new_req(last_g);
    end
    chk("t2_b2b", got.size(), 9);
    foreach (got[k]) chk("t2_res_order", got[k].id, k % NR);
    for (int i = 0; i < NR; i++) rv[i] = 1'b0;
    drain();

    // Operand extremes
    do_reset();
    set_req(0, -131072, -131072);
    set_req(1, 131071, -131072);
    for (int c = 0; c < 6; c++) step();
    chk("t3_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t3_p_max", got[0].p, 64'sd17179869184);
      chk("t3_p_min", got[1].p, -64'sd17179738112);
      chk("t3_id1", got[1].id, 1);
    end

    // Six requests with the consumer stalling for cycles 4..7
    do_reset();
    for (int i = 0; i < NR; i++) new_req(i);
    reqs = NR;
    held_p = '0;
    for (int c = 0; c < 20; c++) begin
      rr = !(c >= 4 && c <= 7);
      step();
      if (c >= 4 && c <= 7) begin
        chk("t4_stall_ready", obs_ready, 0);
        if (c == 4) held_p = obs_p;
        else chk("t4_hold_p", obs_p, held_p);
      end
      if (last_fire && reqs < 6) begin new_req(last_g); reqs++; end
    end
    rr = 1'b1;
    chk("t4_count", got.size(), 6);
    foreach (got[k]) chk("t4_order", got[k].id, k % NR);

    // Drop en with three results in flight and requests pending
    for (int i = 0; i < NR; i++) new_req(i);
    for (int c = 0; c < 3; c++) step();
    t_en = 1'b0;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t5_no_grant", obs_ready, 0);
      if (c == 2) chk("t5_idle_last", obs_idle, 0);
      if (c == 3) chk("t5_idle_after", obs_idle, 1);
    end
    chk("t5_count", got.size(), 3);
    t_en = 1'b1;

    // Reset with two results in flight
    for (int i = 0; i < NR; i++) rv[i] = 1'b0;
    set_req(1, 100, 7);
    set_req(2, -9, 11);
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    #1;
    chk("t6_valid_pre", bus.res_valid, 1);
    apply_reset();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (obs_valid) seen++;
    end
    chk("t6_no_stale", seen, 0);
    for (int i = 0; i < NR; i++) new_req(i);
    step();
    chk("t6_ptr0", last_g, 0);
    drain();

    // Random traffic with random backpressure and en
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
          if ($urandom_range(0, 7) == 0) ra[i] = {1'b1, {(AW-1){1'b0}}};
          if ($urandom_range(0, 7) == 0) rb[i] = {1'b0, {(BW-1){1'b1}}};
        end
      rr   = ($urandom_range(0, 3) != 0);
      t_en = ($urandom_range(0, 9) != 0);
      step();
    end
    rr = 1'b1;
    t_en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
